// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: reset and lock sequencer for the fractional PLL that
// generates the VGA pixel clock and the audio clock. Runs on the 50 MHz
// reference clock, holds the PLL in reset, waits for a qualified lock with
// retry on timeout, and releases the downstream domain reset (sys_rst_n) only
// after lock has been stable for LOCK_STABLE_CYC cycles.
//
// Build option: define PLL_SEQ_RELOCK_EN to re-reset the PLL on lock loss in
// RUN. Leave it undefined (default) to enter the sticky FAULT state instead.
module pll_lock_sequencer #(
    parameter int unsigned RST_HOLD_CYC     = 500,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned MAX_RETRY        = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt
);

    localparam int unsigned MAX_AB  = (RST_HOLD_CYC > LOCK_TIMEOUT_CYC) ? RST_HOLD_CYC : LOCK_TIMEOUT_CYC;
    localparam int unsigned CNT_MAX = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_HOLD_C     = CW'(RST_HOLD_CYC);
    localparam logic [CW-1:0] LOCK_TIMEOUT_C = CW'(LOCK_TIMEOUT_CYC);
    localparam logic [CW-1:0] LOCK_STABLE_C  = CW'(LOCK_STABLE_CYC);
    localparam logic [3:0]    MAX_RETRY_C    = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [3:0]    retry_nx;
    logic [3:0]    retry_inc;
    logic [1:0]    sync_q;
    logic          lock_s;

    logic          pll_rst_nx;
    logic          sys_rst_n_nx;
    logic          ready_nx;
    logic          fault_nx;

    assign lock_s = sync_q[1];

    // Two-flop synchronizer for the asynchronous PLL lock flag
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    // State, shared counter, retry counter and registered outputs
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RESET;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            retry_cnt <= retry_nx;
            pll_rst   <= pll_rst_nx;
            sys_rst_n <= sys_rst_n_nx;
            ready     <= ready_nx;
            fault     <= fault_nx;
        end
    end

    // Next-state, counter and retry logic; restart overrides every other event
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        retry_nx  = retry_cnt;
        retry_inc = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;

        if (restart) begin
            state_nx = ST_RESET;
            cnt_nx   = '0;
            retry_nx = '0;
        end else begin
            case (state)
                ST_RESET: begin
                    if (cnt == RST_HOLD_C) begin
                        state_nx = ST_WAIT_LOCK;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock takes priority over a timeout in the same cycle;
                    // the entry cycle already counts as one locked cycle.
                    if (lock_s) begin
                        state_nx = ST_STABLE;
                        cnt_nx   = CW'(1);
                    end else if (cnt == LOCK_TIMEOUT_C) begin
                        retry_nx = retry_inc;
                        cnt_nx   = '0;
                        state_nx = (retry_inc == MAX_RETRY_C) ? ST_FAULT : ST_RESET;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_nx = ST_WAIT_LOCK;
                        cnt_nx   = '0;
                    end else if (cnt == LOCK_STABLE_C) begin
                        state_nx = ST_RUN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        cnt_nx = '0;
`ifdef PLL_SEQ_RELOCK_EN
                        state_nx = ST_RESET;
`else
                        state_nx = ST_FAULT;
`endif
                    end
                end
                ST_FAULT: begin
                    state_nx = ST_FAULT;
                end
                default: begin
                    state_nx = ST_RESET;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs register with the state
    always_comb begin
        pll_rst_nx   = (state_nx == ST_RESET) || (state_nx == ST_FAULT);
        sys_rst_n_nx = (state_nx == ST_RUN);
        ready_nx     = (state_nx == ST_RUN);
        fault_nx     = (state_nx == ST_FAULT);
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer with small timing parameters.
// Expected output vectors {pll_rst, sys_rst_n, ready, fault, retry_cnt} are
// queued with their due cycle when stimulus is applied and compared on the
// falling edge of that cycle. Honours PLL_SEQ_RELOCK_EN like the design.
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;

    int unsigned cyc     = 0;
    int unsigned n_check = 0;
    int unsigned n_pass  = 0;

    typedef struct {
        int unsigned cyc;
        string       tag;
        logic [7:0]  v;
    } exp_t;

    exp_t sb[$];

    pll_lock_sequencer #(
        .RST_HOLD_CYC     (4),
        .LOCK_TIMEOUT_CYC (20),
        .LOCK_STABLE_CYC  (8),
        .MAX_RETRY        (2)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    function automatic logic [7:0] obs();
        return {pll_rst, sys_rst_n, ready, fault, retry_cnt};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_check++;
        if (got !== exp) begin
            $display("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic expect_in(input int unsigned dly, input string tag, input logic [7:0] v);
        exp_t e;
        e.cyc = cyc + dly;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic at(input int unsigned c);
        while (cyc < c) @(negedge refclk);
    endtask

    // Scoreboard: compare every entry that has come due
    always @(negedge refclk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, obs(), e.v);
        end
    end

    initial begin
        int unsigned e0, lk, l2, e1, e2, p;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;

        // Reset values and nominal lock sequence
        at(2);
        expect_in(1, "reset_state", 8'b1000_0000);
        at(4);
        rst_n = 1'b1;
        e0 = cyc;
        expect_in(4, "rst_hold", 8'b1000_0000);
        expect_in(5, "rst_release", 8'b0000_0000);
        lk = e0 + 15;
        at(lk);
        pll_locked = 1'b1;
        expect_in(10, "pre_run", 8'b0000_0000);
        expect_in(11, "run_entry", 8'b0110_0000);

        // Lock loss in RUN
        l2 = lk + 27;
        at(l2);
        pll_locked = 1'b0;
        expect_in(2, "run_before_loss", 8'b0110_0000);
`ifdef PLL_SEQ_RELOCK_EN
        expect_in(3, "loss_relock", 8'b1000_0000);
        expect_in(7, "relock_hold", 8'b1000_0000);
        expect_in(8, "relock_wait", 8'b0000_0000);
`else
        expect_in(3, "loss_fault", 8'b1001_0000);
        expect_in(10, "loss_sticky", 8'b1001_0000);
`endif

        // Restart, then two timeout rounds into FAULT
        e1 = l2 + 15;
        at(e1);
        restart = 1'b1;
        expect_in(1,  "restart", 8'b1000_0000);
        expect_in(5,  "hold1_end", 8'b1000_0000);
        expect_in(6,  "wait1", 8'b0000_0000);
        expect_in(26, "wait1_end", 8'b0000_0000);
        expect_in(27, "retry1", 8'b1000_0001);
        expect_in(31, "hold2_end", 8'b1000_0001);
        expect_in(32, "wait2", 8'b0000_0001);
        expect_in(52, "wait2_end", 8'b0000_0001);
        expect_in(53, "timeout_fault", 8'b1001_0010);
        expect_in(80, "fault_sticky", 8'b1001_0010);
        @(negedge refclk);
        restart = 1'b0;

        // Restart coinciding with the second timeout
        e2 = e1 + 82;
        at(e2);
        restart = 1'b1;
        expect_in(1,  "restart2", 8'b1000_0000);
        expect_in(27, "retry1_b", 8'b1000_0001);
        expect_in(52, "pre_prio", 8'b0000_0001);
        @(negedge refclk);
        restart = 1'b0;
        at(e2 + 52);
        restart = 1'b1;
        expect_in(1,  "restart_prio", 8'b1000_0000);
        expect_in(5,  "prio_hold", 8'b1000_0000);
        expect_in(6,  "prio_release", 8'b0000_0000);
        expect_in(28, "retry_once", 8'b1000_0001);
        @(negedge refclk);
        restart = 1'b0;

        // Glitchy lock in STABLE, retry_cnt must stay at 1
        p  = e2 + 53;
        lk = p + 40;
        at(lk);
        pll_locked = 1'b1;
        expect_in(7,  "stable5", 8'b0000_0001);
        expect_in(11, "glitch_norun", 8'b0000_0001);
        expect_in(19, "pre_relock_run", 8'b0000_0001);
        expect_in(20, "relock_run", 8'b0110_0001);
        expect_in(24, "run_steady", 8'b0110_0001);
        at(lk + 7);
        pll_locked = 1'b0;
        at(lk + 9);
        pll_locked = 1'b1;

        // Asynchronous reset between clock edges while in RUN
        at(lk + 25);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", obs(), 8'b1000_0000);
        at(lk + 28);
        rst_n = 1'b1;
        at(lk + 31);

        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
